reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the single-cycle ARM register file, for the pipelined datapath.
- Holds r0..r14 and adds:
  - N read ports and M write ports.
  - Optional write-to-read bypass.
  - A per-register busy scoreboard for hazard detection.
- r15 reads return the PC-relative value supplied by fetch.
- Writes to r15 are not stored; they become a registered branch-redirect output.

Parameters:
DATA_W, 32, register width in bits
NUM_RD, 3, number of read ports (Rn, Rm, Rs/Rd-for-STR)
NUM_WR, 2, number of write ports (ALU result, load writeback)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
r15  in  DATA_W  PC+8 value, returned for any read of address 15
ra  in  NUM_RD x 4  read addresses
rd  out  NUM_RD x DATA_W  read data, combinational
rd_busy  out  NUM_RD  1 = addressed register has an outstanding producer
we  in  NUM_WR  write enables
wa  in  NUM_WR x 4  write addresses
wd  in  NUM_WR x DATA_W  write data
iss_valid  in  1  instruction issued that will later write iss_addr
iss_addr  in  4  destination of issued instruction
pc_wr_valid  out  1  registered pulse: a write to r15 occurred last cycle
pc_wr_data  out  DATA_W  target address accompanying pc_wr_valid

Behaviour:
- Reset (async, rst_n=0):
  - r0..r14 <= 0.
  - All busy bits <= 0.
  - pc_wr_valid <= 0, pc_wr_data <= 0.
  - Reset takes effect immediately; it overrides any write, issue or pending redirect in that cycle.
- Reads (combinational):
  - ra==15 -> rd=r15, rd_busy=0.
  - Otherwise rd = stored register and rd_busy = busy[ra].
  - BYPASS=1 and some port k has we[k] && wa[k]==ra (ra!=15):
    - rd = wd of the highest-index such port.
    - rd_busy=0.
- Writes (posedge clk), each port k with we[k]:
  - wa[k] in 0..14 -> register[wa[k]] <= wd[k].
  - wa[k]==15 -> not stored.
  - Several ports writing the same address in one cycle: highest index wins.
- PC redirect:
  - Any enabled write to address 15 -> next cycle pc_wr_valid=1 and pc_wr_data = wd of the highest-index port targeting 15.
  - Otherwise pc_wr_valid=0.
  - pc_wr_data holds its last value when pc_wr_valid=0.
  - Latency is exactly 1 cycle.
- Scoreboard (15 busy bits, r0..r14):
  - iss_valid && iss_addr!=15 -> busy[iss_addr] <= 1.
  - Each enabled write port with wa in 0..14 -> busy[wa] <= 0.
  - Set and clear on the same address in the same cycle -> set wins; the new producer is outstanding.
  - iss_addr==15 is ignored; branches are tracked by the pipeline, not here.
  - A clear for a register that is not busy is legal and has no effect.
  - Multiple outstanding producers per register are not counted; a single bit is used, and the pipeline guarantees in-order writeback per register.
- No state exists for address 15; a read of 15 never depends on wd/we.
- Timing: read path = address decode + bypass mux. There are no read-side flops, so read latency is 0 cycles.

Decomposition:
- Shared package rf_pkg:
  - REG_ADDR_W=4.
  - PC_IDX=4'd15.
  - NUM_ARCH_REGS=15.
  - typedef reg_addr_t.
- Sub-module rf_scoreboard contains:
  - The 15 busy bits.
  - Set/clear priority logic.
  - Busy lookup for NUM_RD addresses.
- Storage, write-port priority, bypass mux and the PC-redirect register remain in reg_file_mp.

Test Plan:
- Reset, then read all 16 addresses on port 0 with r15=0x108 -> r0..r14 read 0, r15 reads 0x108, all rd_busy=0, pc_wr_valid=0.
- Write r3=0xDEADBEEF via port 0, then next cycle read ra[1]=3 -> rd[1]=0xDEADBEEF.
- Bypass: in the same cycle, we[1]=1 with wa=5, wd=0x55, and ra[2]=5 -> BYPASS=1 gives rd[2]=0x55 that cycle; BYPASS=0 gives the old value, and 0x55 the next cycle.
- Write collision: both ports write r7 (port0 0x1, port1 0x2) -> r7=0x2 afterwards.
- Scoreboard:
  - Issue r4 -> rd_busy=1 next cycle.
  - Issue r4 while port0 writes r4 -> still busy.
  - Later write r4 with no issue -> busy clears.
  - Issue r15 -> no busy change.
- PC redirect and reset:
  - Port1 writes address 15 with 0x2000 -> next cycle pc_wr_valid=1, pc_wr_data=0x2000; the following cycle pc_wr_valid=0.
  - Repeat the same write, then assert rst_n=0 mid-cycle before the edge -> pc_wr_valid stays 0, busy bits cleared, registers zeroed.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port ARM register file and its scoreboard.
package rf_pkg;
  localparam int unsigned REG_ADDR_W    = 4;
  localparam int unsigned NUM_ARCH_REGS = 15;
  localparam logic [REG_ADDR_W-1:0] PC_IDX = 4'd15;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for r0..r14: set on issue, cleared on writeback, set wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NUM_RD = 3,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iss_valid,
  input  reg_addr_t              iss_addr,
  input  logic [NUM_WR-1:0]      we,
  input  reg_addr_t [NUM_WR-1:0] wa,
  input  reg_addr_t [NUM_RD-1:0] ra,
  output logic [NUM_RD-1:0]      busy_rd
);

  logic [NUM_ARCH_REGS-1:0] busy;
  logic [NUM_ARCH_REGS-1:0] busy_nxt;

  // Clears applied first so a same-cycle issue to the same register overrides them.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (we[k] && wa[k] != PC_IDX) busy_nxt[wa[k]] = 1'b0;
    end
    if (iss_valid && iss_addr != PC_IDX) busy_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_comb begin
    busy_rd = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (ra[i] != PC_IDX) busy_rd[i] = busy[ra[i]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port ARM register file: r0..r14 storage, optional write bypass,
// r15 read from fetch, r15 writes turned into a registered branch redirect.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_RD = 3,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_W-1:0]              r15,
  input  logic [NUM_RD-1:0][3:0]         ra,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              we,
  input  logic [NUM_WR-1:0][3:0]         wa,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wd,
  input  logic                           iss_valid,
  input  logic [3:0]                     iss_addr,
  output logic                           pc_wr_valid,
  output logic [DATA_W-1:0]              pc_wr_data
);

  logic [NUM_ARCH_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_RD-1:0]                    sb_busy;
  logic [NUM_RD-1:0]                    byp_hit;
  logic                                 pc_hit;
  logic [DATA_W-1:0]                    pc_data;

  rf_scoreboard #(
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .we        (we),
    .wa        (wa),
    .ra        (ra),
    .busy_rd   (sb_busy)
  );

  // Later loop iterations override earlier ones, so the highest port wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (we[k] && wa[k] != PC_IDX) regs[wa[k]] <= wd[k];
      end
    end
  end

  always_comb begin
    pc_hit  = 1'b0;
    pc_data = '0;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (we[k] && wa[k] == PC_IDX) begin
        pc_hit  = 1'b1;
        pc_data = wd[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_wr_valid <= 1'b0;
      pc_wr_data  <= '0;
    end else begin
      pc_wr_valid <= pc_hit;
      if (pc_hit) pc_wr_data <= pc_data;
    end
  end

  always_comb begin
    rd      = '0;
    byp_hit = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (ra[i] == PC_IDX) begin
        rd[i] = r15;
      end else begin
        rd[i] = regs[ra[i]];
        if (BYPASS != 0) begin
          for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (we[k] && wa[k] == ra[i]) begin
              rd[i]      = wd[k];
              byp_hit[i] = 1'b1;
            end
          end
        end
      end
    end
    rd_busy = sb_busy & ~byp_hit;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances share stimulus and a reference model.
module tb_reg_file_mp;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [DW-1:0]        r15;
  logic [2:0][3:0]      ra;
  logic [1:0]           we;
  logic [1:0][3:0]      wa;
  logic [1:0][DW-1:0]   wd;
  logic                 iss_valid;
  logic [3:0]           iss_addr;

  logic [2:0][DW-1:0]   rd_b1, rd_b0;
  logic [2:0]           busy_b1, busy_b0;
  logic                 pcv_b1, pcv_b0;
  logic [DW-1:0]        pcd_b1, pcd_b0;

  int n_total = 0;
  int n_pass  = 0;

  // reference state
  logic [DW-1:0] m_regs [15];
  bit            m_busy [15];
  bit            m_pcv;
  logic [DW-1:0] m_pcd;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .NUM_RD(3), .NUM_WR(2), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .r15(r15), .ra(ra), .rd(rd_b1), .rd_busy(busy_b1),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .pc_wr_valid(pcv_b1), .pc_wr_data(pcd_b1)
  );

  reg_file_mp #(.DATA_W(DW), .NUM_RD(3), .NUM_WR(2), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .r15(r15), .ra(ra), .rd(rd_b0), .rd_busy(busy_b0),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .pc_wr_valid(pcv_b0), .pc_wr_data(pcd_b0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 15; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_pcv = 1'b0;
    m_pcd = '0;
  endtask

  // Value a read of address a should return, given the current write-port inputs.
  function automatic logic [DW-1:0] exp_rd(input bit byp, input int a);
    logic [DW-1:0] v;
    if (a == 15) return r15;
    v = m_regs[a];
    if (byp) for (int k = 0; k < 2; k++) if (we[k] && int'(wa[k]) == a) v = wd[k];
    return v;
  endfunction

  function automatic bit exp_busy(input bit byp, input int a);
    if (a == 15) return 1'b0;
    if (byp) for (int k = 0; k < 2; k++) if (we[k] && int'(wa[k]) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_clock();
    bit            hit = 1'b0;
    logic [DW-1:0] tgt = '0;
    for (int k = 0; k < 2; k++) begin
      if (we[k]) begin
        if (wa[k] == 4'd15) begin
          hit = 1'b1;
          tgt = wd[k];
        end else begin
          m_regs[wa[k]] = wd[k];
          m_busy[wa[k]] = 1'b0;
        end
      end
    end
    if (iss_valid && iss_addr != 4'd15) m_busy[iss_addr] = 1'b1;
    m_pcv = hit;
    if (hit) m_pcd = tgt;
  endtask

  task automatic check_reads();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rd%0d_byp1_a%0d", i, ra[i]), rd_b1[i], exp_rd(1'b1, ra[i]));
      check($sformatf("rd%0d_byp0_a%0d", i, ra[i]), rd_b0[i], exp_rd(1'b0, ra[i]));
      check($sformatf("busy%0d_byp1_a%0d", i, ra[i]), busy_b1[i], exp_busy(1'b1, ra[i]));
      check($sformatf("busy%0d_byp0_a%0d", i, ra[i]), busy_b0[i], exp_busy(1'b0, ra[i]));
    end
  endtask

  task automatic check_pc();
    check("pc_valid_byp1", pcv_b1, m_pcv);
    check("pc_valid_byp0", pcv_b0, m_pcv);
    check("pc_data_byp1", pcd_b1, m_pcd);
    check("pc_data_byp0", pcd_b0, m_pcd);
  endtask

  task automatic idle();
    ra = '0; we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    #1 check_reads();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_pc();
  endtask

  initial begin
    idle();
    r15   = 32'h108;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_pc();

    for (int a = 0; a < 16; a++) begin
      ra[0] = 4'(a);
      step();
    end

    idle(); we[0] = 1'b1; wa[0] = 4'd3; wd[0] = 32'hDEADBEEF; step();
    idle(); ra[1] = 4'd3; step();
    check("r3_readback", rd_b1[1], 64'hDEADBEEF);

    idle(); we[1] = 1'b1; wa[1] = 4'd5; wd[1] = 32'h55; ra[2] = 4'd5; #1;
    check("bypass_on_r5", rd_b1[2], 64'h55);
    check("bypass_off_r5", rd_b0[2], 64'h0);
    step();
    idle(); ra[2] = 4'd5; step();

    idle(); we = 2'b11; wa[0] = 4'd7; wa[1] = 4'd7; wd[0] = 32'h1; wd[1] = 32'h2; step();
    idle(); ra[0] = 4'd7; step();
    check("collision_r7", rd_b0[0], 64'h2);

    idle(); iss_valid = 1'b1; iss_addr = 4'd4; step();
    idle(); ra[0] = 4'd4; step();
    check("busy_after_issue", busy_b0[0], 64'h1);
    idle(); iss_valid = 1'b1; iss_addr = 4'd4; we[0] = 1'b1; wa[0] = 4'd4; wd[0] = 32'h44; step();
    idle(); ra[0] = 4'd4; step();
    check("set_beats_clear", busy_b1[0], 64'h1);
    idle(); we[0] = 1'b1; wa[0] = 4'd4; wd[0] = 32'h45; step();
    idle(); ra[0] = 4'd4; step();
    check("busy_cleared", busy_b0[0], 64'h0);
    idle(); iss_valid = 1'b1; iss_addr = 4'd15; ra[1] = 4'd15; step();
    idle(); ra[0] = 4'd15; ra[1] = 4'd4; step();

    idle(); we[1] = 1'b1; wa[1] = 4'd15; wd[1] = 32'h2000; step();
    check("redirect_valid", pcv_b1, 64'h1);
    check("redirect_data", pcd_b1, 64'h2000);
    idle(); step();
    check("redirect_drops", pcv_b1, 64'h0);

    idle(); iss_valid = 1'b1; iss_addr = 4'd2; step();
    idle(); iss_valid = 1'b1; iss_addr = 4'd9; step();
    idle(); we[1] = 1'b1; wa[1] = 4'd15; wd[1] = 32'h2000;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_pc();
    @(posedge clk);
    @(negedge clk);
    check_pc();
    idle(); ra[0] = 4'd2; ra[1] = 4'd9; ra[2] = 4'd3;
    #1 check_reads();
    @(negedge clk);
    rst_n = 1'b1;
    idle(); ra[0] = 4'd7; ra[1] = 4'd4; ra[2] = 4'd5; step();

    for (int n = 0; n < 300; n++) begin
      idle();
      r15 = $urandom;
      for (int i = 0; i < 3; i++) ra[i] = 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        we[k] = 1'($urandom);
        wa[k] = 4'($urandom_range(0, 15));
        wd[k] = $urandom;
      end
      iss_valid = 1'($urandom);
      iss_addr  = 4'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
